// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial sequence detector. Shifts qualified serial bits into a
// MAX_LEN-bit history and compares the newest `len` bits against a runtime
// programmable pattern using a masked compare. A match produces a registered
// one-cycle pulse on z, in the cycle after the completing bit is accepted.
// Overlapping and non-overlapping detection are both supported.
//
// Optional feature (compile-time macro SEQ_DET_COUNT_EN):
//   defined   -> match_cnt counts matches and saturates at 2^CNT_W-1
//   undefined -> no counter flops, match_cnt is tied to 0 (ports unchanged)
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   clear      in   1        synchronous clear of history, fill, z, match_cnt
//   en         in   1        x carries a valid bit this cycle
//   x          in   1        serial input bit
//   pattern    in   MAX_LEN  pattern[len-1] = first bit, pattern[0] = last bit
//   len        in   LEN_W    active pattern length, valid 1..MAX_LEN
//   overlap    in   1        1 = overlapping, 0 = non-overlapping detection
//   z          out  1        registered match pulse
//   match_cnt  out  CNT_W    saturating match count (0 without the macro)
// -----------------------------------------------------------------------------
module seq_detector_param #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   input  logic               x,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic               overlap,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt
);

   // fill must represent 0..MAX_LEN inclusive
   localparam int FILL_W = $clog2(MAX_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_n;
   logic [MAX_LEN-1:0] mask;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_n;
   logic [FILL_W-1:0]  fill_after;
   logic               len_ok;
   logic               fill_ok;
   logic               match;

   // Next history/fill and the masked compare against the programmed pattern.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      hist_n     = {hist[MAX_LEN-2:0], x};
      fill_n     = (fill == FILL_MAX) ? fill : fill + 1'b1;
      len_ok     = (len != '0) && (len <= LEN_MAX);
      fill_ok    = 32'(fill_n) >= 32'(len);
      mask       = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len);
      end
      match      = en && len_ok && fill_ok && ((hist_n & mask) == (pattern & mask));
      // Non-overlapping mode forgets the bits that formed the match.
      fill_after = (match && !overlap) ? '0 : fill_n;
   end

`ifdef SEQ_DET_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] cnt;
   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
         cnt  <= '0;
`endif
      end else if (clear) begin
         // The bit presented alongside clear is discarded.
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
         cnt  <= '0;
`endif
      end else if (en) begin
         hist <= hist_n;
         fill <= fill_after;
         z    <= match;
`ifdef SEQ_DET_COUNT_EN
         if (match && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
         end
`endif
      end else begin
         // Idle cycle: history and fill hold, so gaps never break a partial match.
         z <= 1'b0;
      end
   end

endmodule
